key_debounce_multi: RTL and testbench

//  Multi-channel successor to the single-key 20 ms filter: debounces KEY_NUM independent active-low keys.

---
 rtl/key_pkg.sv | 16 +
 rtl/key_chan.sv | 130 +++++++++++++
 rtl/key_debounce_multi.sv | 36 +++
 tb/tb_key_debounce_multi.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared state encoding and default timing for the multi-key debouncer
package key_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESS_F = 2'd1,
      DOWN    = 2'd2,
      REL_F   = 2'd3
   } key_st_t;

   // Defaults assume a 50 MHz sys_clk: 20 ms filter, 1 s long press, 200 ms repeat
   localparam int unsigned CNT_MAX_DEF    = 999_999;
   localparam int unsigned LONG_MAX_DEF   = 49_999_999;
   localparam int unsigned REPEAT_MAX_DEF = 9_999_999;

endpackage

// File: rtl/key_chan.sv
// rtl/key_chan.sv - one key channel: 2-flop synchroniser, debounce FSM, long-press timer
// Auto-repeat on long hold is built only when KEY_REPEAT_EN is defined.
module key_chan
   import key_pkg::*;
#(
   parameter int unsigned CNT_MAX    = CNT_MAX_DEF,
   parameter int unsigned LONG_MAX   = LONG_MAX_DEF,
   parameter int unsigned REPEAT_MAX = REPEAT_MAX_DEF
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic key_in,
   output logic key_state,
   output logic key_press,
   output logic key_release,
   output logic key_long
);

   localparam int unsigned CW = $clog2(CNT_MAX + 1);
   localparam int unsigned LW = $clog2(LONG_MAX + 1);

   logic          k_meta;
   logic          ksync;
   key_st_t       st;
   logic [CW-1:0] cnt;
   logic [LW-1:0] lcnt;
   logic          long_done;

`ifdef KEY_REPEAT_EN
   localparam int unsigned RW = $clog2(REPEAT_MAX + 1);
   logic [RW-1:0] rcnt;
`else
   // REPEAT_MAX stays a legal override but has no effect without auto-repeat
   if (REPEAT_MAX == 0) begin : g_no_repeat
   end
`endif

   // Flops reset to 1 so a released key is seen as released straight out of reset
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         k_meta <= 1'b1;
         ksync  <= 1'b1;
      end else begin
         k_meta <= key_in;
         ksync  <= k_meta;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         st          <= IDLE;
         cnt         <= '0;
         lcnt        <= '0;
         long_done   <= 1'b0;
         key_state   <= 1'b0;
         key_press   <= 1'b0;
         key_release <= 1'b0;
         key_long    <= 1'b0;
`ifdef KEY_REPEAT_EN
         rcnt        <= '0;
`endif
      end else begin
         key_press   <= 1'b0;
         key_release <= 1'b0;
         key_long    <= 1'b0;
         case (st)
            IDLE: begin
               if (!ksync) begin
                  st  <= PRESS_F;
                  cnt <= '0;
               end
            end
            PRESS_F: begin
               if (ksync) begin
                  st  <= IDLE;
                  cnt <= '0;
               end else if (cnt == CW'(CNT_MAX)) begin
                  st        <= DOWN;
                  key_press <= 1'b1;
                  key_state <= 1'b1;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DOWN: begin
               // lcnt parks at LONG_MAX; long_done keeps key_long to one pulse per press
               if (!long_done) begin
                  if (lcnt == LW'(LONG_MAX)) begin
                     key_long  <= 1'b1;
                     long_done <= 1'b1;
                  end else begin
                     lcnt <= lcnt + LW'(1);
                  end
               end
`ifdef KEY_REPEAT_EN
               if (ksync) begin
                  rcnt <= '0;
               end else if (long_done) begin
                  if (rcnt == RW'(REPEAT_MAX)) begin
                     rcnt      <= '0;
                     key_press <= 1'b1;
                  end else begin
                     rcnt <= rcnt + RW'(1);
                  end
               end
`endif
               if (ksync) begin
                  st  <= REL_F;
                  cnt <= '0;
               end
            end
            REL_F: begin
               if (!ksync) begin
                  st <= DOWN;
               end else if (cnt == CW'(CNT_MAX)) begin
                  st          <= IDLE;
                  key_release <= 1'b1;
                  key_state   <= 1'b0;
                  lcnt        <= '0;
                  long_done   <= 1'b0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: st <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/key_debounce_multi.sv
// rtl/key_debounce_multi.sv - KEY_NUM independent active-low key debouncers
// Optional auto-repeat on long hold: define KEY_REPEAT_EN.
module key_debounce_multi
   import key_pkg::*;
#(
   parameter int unsigned KEY_NUM    = 4,
   parameter int unsigned CNT_MAX    = CNT_MAX_DEF,
   parameter int unsigned LONG_MAX   = LONG_MAX_DEF,
   parameter int unsigned REPEAT_MAX = REPEAT_MAX_DEF
) (
   input  logic               sys_clk,
   input  logic               sys_rst_n,
   input  logic [KEY_NUM-1:0] key_in,
   output logic [KEY_NUM-1:0] key_state,
   output logic [KEY_NUM-1:0] key_press,
   output logic [KEY_NUM-1:0] key_release,
   output logic [KEY_NUM-1:0] key_long
);

   for (genvar i = 0; i < KEY_NUM; i++) begin : g_chan
      key_chan #(
         .CNT_MAX    (CNT_MAX),
         .LONG_MAX   (LONG_MAX),
         .REPEAT_MAX (REPEAT_MAX)
      ) u_chan (
         .sys_clk     (sys_clk),
         .sys_rst_n   (sys_rst_n),
         .key_in      (key_in[i]),
         .key_state   (key_state[i]),
         .key_press   (key_press[i]),
         .key_release (key_release[i]),
         .key_long    (key_long[i])
      );
   end

endmodule

// File: tb/tb_key_debounce_multi.sv
// tb/tb_key_debounce_multi.sv - directed and random checks of key_debounce_multi against a run-length model
module tb_key_debounce_multi;

   localparam int KN = 4;
   localparam int CM = 9;
   localparam int LM = 49;
   localparam int RM = 19;
`ifdef KEY_REPEAT_EN
   localparam int T7_PRESSES = 3;
`else
   localparam int T7_PRESSES = 1;
`endif

   logic          sys_clk = 1'b0;
   logic          sys_rst_n = 1'b1;
   logic [KN-1:0] key_in = '1;
   logic [KN-1:0] key_state, key_press, key_release, key_long;

   int total = 0;
   int bad = 0;
   int edge_n = 0;
   int first_press[KN], first_rel[KN], first_long[KN], n_press[KN], n_rel[KN];

   // Model: synchroniser pipe, plus per key the debounced level, length of the current run of
   // samples opposing that level, DOWN cycles since press, and DOWN cycles since last repeat.
   logic [KN-1:0] m_s1, m_s2;
   bit            m_pr[KN];
   int            m_run[KN], m_downs[KN], m_rep[KN];
   logic [KN-1:0] e_state, e_press, e_release, e_long;

   always #5 sys_clk = ~sys_clk;

   key_debounce_multi #(
      .KEY_NUM    (KN),
      .CNT_MAX    (CM),
      .LONG_MAX   (LM),
      .REPEAT_MAX (RM)
   ) dut (
      .sys_clk     (sys_clk),
      .sys_rst_n   (sys_rst_n),
      .key_in      (key_in),
      .key_state   (key_state),
      .key_press   (key_press),
      .key_release (key_release),
      .key_long    (key_long)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_s1 = '1;
      m_s2 = '1;
      e_state = '0;
      e_press = '0;
      e_release = '0;
      e_long = '0;
      for (int k = 0; k < KN; k++) begin
         m_pr[k] = 0;
         m_run[k] = 0;
         m_downs[k] = 0;
         m_rep[k] = 0;
      end
   endtask

   task automatic model_edge();
      logic [KN-1:0] ks;
      bit            in_down;
      ks = m_s2;
      m_s2 = m_s1;
      m_s1 = key_in;
      e_press = '0;
      e_release = '0;
      e_long = '0;
      for (int k = 0; k < KN; k++) begin
         if (!m_pr[k]) begin
            m_run[k] = ks[k] ? 0 : m_run[k] + 1;
            if (m_run[k] == CM + 2) begin
               m_pr[k] = 1;
               m_run[k] = 0;
               m_downs[k] = 0;
               m_rep[k] = 0;
               e_press[k] = 1'b1;
               e_state[k] = 1'b1;
            end
         end else begin
            in_down = (m_run[k] == 0);
            if (in_down) begin
               m_downs[k]++;
               if (m_downs[k] == LM + 1) e_long[k] = 1'b1;
`ifdef KEY_REPEAT_EN
               if (ks[k]) m_rep[k] = 0;
               else if (m_downs[k] > LM + 1) begin
                  m_rep[k]++;
                  if (m_rep[k] == RM + 1) begin
                     m_rep[k] = 0;
                     e_press[k] = 1'b1;
                  end
               end
`endif
            end
            m_run[k] = ks[k] ? m_run[k] + 1 : 0;
            if (m_run[k] == CM + 2) begin
               m_pr[k] = 0;
               m_run[k] = 0;
               e_release[k] = 1'b1;
               e_state[k] = 1'b0;
            end
         end
      end
   endtask

   task automatic clr_trk();
      edge_n = 0;
      for (int k = 0; k < KN; k++) begin
         first_press[k] = -1;
         first_rel[k] = -1;
         first_long[k] = -1;
         n_press[k] = 0;
         n_rel[k] = 0;
      end
   endtask

   task automatic step(input logic [KN-1:0] k_val);
      key_in = k_val;
      @(posedge sys_clk);
      if (sys_rst_n) model_edge();
      @(negedge sys_clk);
      edge_n++;
      check("state", key_state, e_state);
      check("press", key_press, e_press);
      check("release", key_release, e_release);
      check("long", key_long, e_long);
      check("press_and_release", key_press & key_release, '0);
      for (int k = 0; k < KN; k++) begin
         if (key_press[k]) begin
            n_press[k]++;
            if (first_press[k] < 0) first_press[k] = edge_n;
         end
         if (key_release[k]) begin
            n_rel[k]++;
            if (first_rel[k] < 0) first_rel[k] = edge_n;
         end
         if (key_long[k] && first_long[k] < 0) first_long[k] = edge_n;
      end
   endtask

   task automatic hold(input logic [KN-1:0] k_val, input int n);
      for (int i = 0; i < n; i++) step(k_val);
   endtask

   task automatic do_reset();
      sys_rst_n = 1'b0;
      #1;
      model_reset();
      check("rst_state", key_state, '0);
      check("rst_press", key_press, '0);
      check("rst_release", key_release, '0);
      check("rst_long", key_long, '0);
      repeat (3) @(negedge sys_clk);
      sys_rst_n = 1'b1;
   endtask

   initial begin
      logic [KN-1:0] lv;
      int            left[KN];
      int            r;

      #2;
      do_reset();

      // 1: single press latency and release latency
      clr_trk();
      hold(4'b1110, 20);
      check("t1_press_edge", first_press[0], 13);
      check("t1_state", key_state, 4'b0001);
      check("t1_other_press", n_press[1] + n_press[2] + n_press[3], 0);
      clr_trk();
      hold(4'b1111, 20);
      check("t1_rel_edge", first_rel[0], 13);

      // 2: two short lows never confirm
      clr_trk();
      hold(4'b1101, 6);
      hold(4'b1111, 3);
      hold(4'b1101, 6);
      hold(4'b1111, 5);
      check("t2_no_press", n_press[1], 0);

      // 3: long hold then release
      clr_trk();
      hold(4'b1011, 80);
      check("t3_press_edge", first_press[2], 13);
      check("t3_long_delay", first_long[2] - first_press[2], 50);
      clr_trk();
      hold(4'b1111, 20);
      check("t3_rel_edge", first_rel[2], 13);

      // 4: simultaneous presses
      clr_trk();
      hold(4'b0110, 20);
      check("t4_press0", first_press[0], 13);
      check("t4_press3", first_press[3], 13);

      // 5: release bounce while held
      clr_trk();
      hold(4'b1111, 5);
      hold(4'b0110, 20);
      check("t5_no_rel", n_rel[0] + n_rel[3], 0);
      check("t5_state", key_state, 4'b1001);

      // 6: reset mid-filter and mid-hold
      hold(4'b1111, 20);
      clr_trk();
      hold(4'b1110, 8);
      do_reset();
      clr_trk();
      hold(4'b1110, 20);
      check("t6_press_edge", first_press[0], 13);
      do_reset();
      clr_trk();
      hold(4'b1111, 15);
      check("t6_no_pulse", n_press[0] + n_rel[0], 0);

      // 7: 120-cycle hold (repeats only with auto-repeat)
      clr_trk();
      hold(4'b1110, 120);
      check("t7_long_edge", first_long[0], 63);
      hold(4'b1111, 20);
      check("t7_presses", n_press[0], T7_PRESSES);

      // random run lengths: glitches, normal presses, long holds
      lv = '1;
      for (int k = 0; k < KN; k++) left[k] = $urandom_range(1, 20);
      for (int c = 0; c < 3000; c++) begin
         for (int k = 0; k < KN; k++) begin
            if (left[k] == 0) begin
               lv[k] = ~lv[k];
               r = $urandom_range(0, 9);
               if (r < 4) left[k] = $urandom_range(1, 12);
               else if (r < 8) left[k] = $urandom_range(12, 40);
               else left[k] = $urandom_range(55, 100);
            end
            left[k]--;
         end
         step(lv);
      end
      hold(4'b1111, 20);
      check("end_state", key_state, '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
